// File: rtl/tl_pkg.sv
// rtl/tl_pkg.sv - shared state encoding and default timings for the intersection controller
package tl_pkg;

  typedef enum logic [2:0] {
    ST_ALL_RED = 3'd0,
    ST_RED_YEL = 3'd1,
    ST_GREEN   = 3'd2,
    ST_YEL     = 3'd3,
    ST_FLASH   = 3'd4
  } tl_state_e;

  localparam int TL_N_DIR   = 2;
  localparam int TL_AR_T    = 1000;
  localparam int TL_RY_T    = 5000;
  localparam int TL_G_T     = 10000;
  localparam int TL_Y_T     = 5000;
  localparam int TL_FLASH_T = 5000;
  localparam int TL_CNT_W   = 16;

endpackage

// File: rtl/tl_phase_timer.sv
// rtl/tl_phase_timer.sv - phase counter with synchronous clear and end-of-duration flag
module tl_phase_timer #(
  parameter int CNT_W = 16
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           clear,
  input  logic [CNT_W:0] duration,
  output logic           done
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)      cnt <= '0;
    else if (clear) cnt <= '0;
    else            cnt <= cnt + CNT_W'(1);
  end

  // duration is one bit wider so a full-range duration still compares correctly
  assign done = ({1'b0, cnt} == duration - (CNT_W + 1)'(1));

endmodule

// File: rtl/traffic_intersection_ctrl.sv
// rtl/traffic_intersection_ctrl.sv - round-robin intersection sequencer with pedestrian latches and flash mode
module traffic_intersection_ctrl
  import tl_pkg::*;
#(
  parameter int N_DIR   = TL_N_DIR,
  parameter int AR_T    = TL_AR_T,
  parameter int RY_T    = TL_RY_T,
  parameter int G_T     = TL_G_T,
  parameter int Y_T     = TL_Y_T,
  parameter int FLASH_T = TL_FLASH_T,
  parameter int CNT_W   = TL_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flash,
  input  logic [N_DIR-1:0] ped_req,
  output logic [N_DIR-1:0] red,
  output logic [N_DIR-1:0] yellow,
  output logic [N_DIR-1:0] green,
  output logic [N_DIR-1:0] walk,
  output logic [1:0]       active_dir
);

  localparam int DW = CNT_W + 1;

  tl_state_e        state, state_n;
  logic [1:0]       dir, dir_n;
  logic             tog, tog_n;
  logic             walk_f, walk_f_n;
  logic             gpend, gpend_n;
  logic [N_DIR-1:0] pend, pend_n;
  logic [N_DIR-1:0] dir_oh, dir_oh_n;
  logic [N_DIR-1:0] red_n, yel_n, grn_n, wlk_n;
  logic [DW-1:0]    dur;
  logic             phase_done;
  logic             tclear;

  assign dir_oh   = N_DIR'(1) << dir;
  assign dir_oh_n = N_DIR'(1) << dir_n;

  always_comb begin
    dur = DW'(AR_T);
    case (state)
      ST_ALL_RED: dur = DW'(AR_T);
      ST_RED_YEL: dur = DW'(RY_T);
      ST_GREEN:   dur = DW'(G_T);
      ST_YEL:     dur = DW'(Y_T);
      ST_FLASH:   dur = DW'(FLASH_T);
      default:    dur = DW'(AR_T);
    endcase
  end

  tl_phase_timer #(.CNT_W(CNT_W)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .clear    (tclear),
    .duration (dur),
    .done     (phase_done)
  );

  always_comb begin
    state_n  = state;
    dir_n    = dir;
    tog_n    = tog;
    walk_f_n = walk_f;
    gpend_n  = gpend;
    pend_n   = pend | ped_req;
    case (state)
      ST_ALL_RED: begin
        if (flash) begin
          state_n = ST_FLASH;
          tog_n   = 1'b1;
        end else if (phase_done) begin
          state_n = ST_RED_YEL;
        end
      end
      ST_RED_YEL: begin
        if (phase_done) begin
          state_n  = ST_GREEN;
          walk_f_n = |(pend_n & dir_oh);
          gpend_n  = 1'b0;
        end
      end
      ST_GREEN: begin
        // requests for the served approach during its green wait for its next turn
        gpend_n = gpend | (|(ped_req & dir_oh));
        if (phase_done) begin
          state_n  = ST_YEL;
          walk_f_n = 1'b0;
          pend_n   = (pend_n & ~dir_oh) | (gpend_n ? dir_oh : '0);
        end
      end
      ST_YEL: begin
        if (phase_done) begin
          state_n = ST_ALL_RED;
          dir_n   = (dir == 2'(N_DIR - 1)) ? 2'd0 : dir + 2'd1;
        end
      end
      ST_FLASH: begin
        if (!flash) begin
          state_n = ST_ALL_RED;
          dir_n   = 2'd0;
          tog_n   = 1'b0;
        end else if (phase_done) begin
          tog_n = ~tog;
        end
      end
      default: state_n = ST_ALL_RED;
    endcase
    tclear = (state_n != state) || ((state == ST_FLASH) && phase_done);
  end

  // lamps decoded from the next state so the registered outputs line up with state
  always_comb begin
    red_n = '0;
    yel_n = '0;
    grn_n = '0;
    wlk_n = '0;
    case (state_n)
      ST_ALL_RED: red_n = '1;
      ST_RED_YEL: begin
        red_n = '1;
        yel_n = dir_oh_n;
      end
      ST_GREEN: begin
        red_n = ~dir_oh_n;
        grn_n = dir_oh_n;
        if (walk_f_n) wlk_n = dir_oh_n;
      end
      ST_YEL: begin
        red_n = ~dir_oh_n;
        yel_n = dir_oh_n;
      end
      ST_FLASH: yel_n = {N_DIR{tog_n}};
      default:  red_n = '1;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= ST_ALL_RED;
      dir    <= 2'd0;
      tog    <= 1'b0;
      walk_f <= 1'b0;
      gpend  <= 1'b0;
      pend   <= '0;
      red    <= '1;
      yellow <= '0;
      green  <= '0;
      walk   <= '0;
    end else begin
      state  <= state_n;
      dir    <= dir_n;
      tog    <= tog_n;
      walk_f <= walk_f_n;
      gpend  <= gpend_n;
      pend   <= pend_n;
      red    <= red_n;
      yellow <= yel_n;
      green  <= grn_n;
      walk   <= wlk_n;
    end
  end

  assign active_dir = dir;

endmodule
